// File: rtl/uart_rx_sequencer.sv
// Frame controller for the UART receive path: start/data/parity/stop sequencing, error checks
// and a one-deep hold register with valid/ready. Optional break detection: UART_RX_BREAK_DET_EN.
module uart_rx_sequencer #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6,
    parameter int EDGE_W  = 5,
    parameter int BIT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic [EDGE_W-1:0] edge_cnt,
    input  logic [BIT_W-1:0]  bit_cnt,
    input  logic              sampled_bit,
    input  logic [DATA_W-1:0] p_data,
    output logic              edge_bit_cnt_enable,
    output logic              bit_cnt_reset,
    output logic              data_sample_en,
    output logic              deser_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              par_err,
    output logic              stp_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic              brk_det,
`endif
    output logic              ovr_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_psel;
    logic [1:0]          w_psel;
    logic [EDGE_W-1:0]   w_cp;
    logic [EDGE_W-1:0]   w_be;
    logic                w_at_cp;
    logic                w_at_be;
    logic                w_last_data;
    logic                w_frame_end;
    logic                w_stop_bad;
    logic                w_is_break;
    logic                w_good;
    logic                w_load;
    logic                r_par_acc;
    logic                r_par_bad;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_par_err;
    logic                r_stp_err;
    logic                r_ovr_err;

    // Unsupported prescale values fall back to 8x oversampling
    always_comb begin
        if (prescale == PRESC_W'(16))
            w_psel = 2'd1;
        else if (prescale == PRESC_W'(32))
            w_psel = 2'd2;
        else
            w_psel = 2'd0;
    end

    // Check point sits at P/2+2 so the sampler's majority vote has settled
    always_comb begin
        case (r_psel)
            2'd1: begin
                w_cp = EDGE_W'(10);
                w_be = EDGE_W'(15);
            end
            2'd2: begin
                w_cp = EDGE_W'(18);
                w_be = EDGE_W'(31);
            end
            default: begin
                w_cp = EDGE_W'(6);
                w_be = EDGE_W'(7);
            end
        endcase
    end

    assign w_at_cp     = (edge_cnt == w_cp);
    assign w_at_be     = (edge_cnt == w_be);
    assign w_last_data = (bit_cnt == BIT_W'(DATA_W));
    assign w_frame_end = (r_state == S_STOP) && w_at_cp;
    assign w_stop_bad  = ~sampled_bit;
    assign w_good      = w_frame_end && !w_stop_bad && !r_par_bad;
    assign w_load      = w_good && (!r_rx_valid || rx_ready);

`ifdef UART_RX_BREAK_DET_EN
    logic r_any_one;
    logic r_brk_det;

    assign w_is_break = w_frame_end && w_stop_bad && !r_any_one;
    assign brk_det    = r_brk_det;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_any_one <= 1'b0;
            r_brk_det <= 1'b0;
        end else begin
            r_brk_det <= w_is_break;
            if (r_state == S_IDLE)
                r_any_one <= 1'b0;
            else if ((r_state == S_DATA || r_state == S_PARITY) && w_at_cp && sampled_bit)
                r_any_one <= 1'b1;
        end
    end
`else
    assign w_is_break = 1'b0;
`endif

    always_comb begin
        w_next              = r_state;
        edge_bit_cnt_enable = 1'b0;
        bit_cnt_reset       = 1'b0;
        data_sample_en      = 1'b0;
        deser_en            = 1'b0;
        case (r_state)
            S_IDLE: begin
                bit_cnt_reset = 1'b1;
                if (!RX_IN)
                    w_next = S_START;
            end
            S_START: begin
                edge_bit_cnt_enable = 1'b1;
                data_sample_en      = 1'b1;
                if (w_at_cp && sampled_bit)
                    w_next = S_IDLE;
                else if (w_at_be)
                    w_next = S_DATA;
            end
            S_DATA: begin
                edge_bit_cnt_enable = 1'b1;
                data_sample_en      = 1'b1;
                deser_en            = w_at_cp;
                if (w_at_be && w_last_data)
                    w_next = par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                edge_bit_cnt_enable = 1'b1;
                data_sample_en      = 1'b1;
                if (w_at_be)
                    w_next = S_STOP;
            end
            S_STOP: begin
                edge_bit_cnt_enable = 1'b1;
                data_sample_en      = 1'b1;
                // Leave at the check point so a start edge half a bit later is not missed
                if (w_at_cp)
                    w_next = w_is_break ? S_BREAK : S_IDLE;
            end
            S_BREAK: begin
                bit_cnt_reset = 1'b1;
                if (RX_IN)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_psel     <= 2'd0;
            r_par_acc  <= 1'b0;
            r_par_bad  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
            r_ovr_err  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_par_err <= w_frame_end && r_par_bad && !w_is_break;
            r_stp_err <= w_frame_end && w_stop_bad && !w_is_break;
            r_ovr_err <= w_good && r_rx_valid && !rx_ready;
            if (r_state == S_IDLE && !RX_IN)
                r_psel <= w_psel;
            if (r_state == S_IDLE) begin
                r_par_acc <= 1'b0;
                r_par_bad <= 1'b0;
            end else begin
                if (r_state == S_DATA && w_at_cp)
                    r_par_acc <= r_par_acc ^ sampled_bit;
                if (r_state == S_PARITY && w_at_cp && (sampled_bit != (r_par_acc ^ par_typ)))
                    r_par_bad <= 1'b1;
            end
            // A load in the same cycle as an accept keeps valid high with the new data
            if (w_load) begin
                r_rx_data  <= p_data;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign par_err  = r_par_err;
    assign stp_err  = r_stp_err;
    assign ovr_err  = r_ovr_err;

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer with behavioural counter, sampler and deserializer models.
module tb_uart_rx_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [4:0] edge_cnt = '0;
    logic [3:0] bit_cnt  = '0;
    logic       sampled_bit;
    logic [7:0] p_data   = '0;
    logic       edge_bit_cnt_enable;
    logic       bit_cnt_reset;
    logic       data_sample_en;
    logic       deser_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       par_err;
    logic       stp_err;
    logic       ovr_err;
`ifdef UART_RX_BREAK_DET_EN
    logic       brk_det;
`endif

    int tb_p      = 8;
    int n_checks  = 0;
    int n_err     = 0;
    int cnt_deser = 0;
    int cnt_err   = 0;

    uart_rx_sequencer #(
        .DATA_W(8), .PRESC_W(6), .EDGE_W(5), .BIT_W(4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .RX_IN               (RX_IN),
        .prescale            (prescale),
        .par_en              (par_en),
        .par_typ             (par_typ),
        .edge_cnt            (edge_cnt),
        .bit_cnt             (bit_cnt),
        .sampled_bit         (sampled_bit),
        .p_data              (p_data),
        .edge_bit_cnt_enable (edge_bit_cnt_enable),
        .bit_cnt_reset       (bit_cnt_reset),
        .data_sample_en      (data_sample_en),
        .deser_en            (deser_en),
        .rx_data             (rx_data),
        .rx_valid            (rx_valid),
        .rx_ready            (rx_ready),
        .par_err             (par_err),
        .stp_err             (stp_err),
`ifdef UART_RX_BREAK_DET_EN
        .brk_det             (brk_det),
`endif
        .ovr_err             (ovr_err)
    );

    always #5 clk = ~clk;

    // Counter model: wraps edge_cnt at P-1 and advances bit_cnt
    always @(posedge clk) begin
        if (bit_cnt_reset) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_bit_cnt_enable) begin
            if (edge_cnt == 5'(tb_p - 1)) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end
        end
    end

    assign sampled_bit = RX_IN;

    // LSB-first deserializer model
    always @(posedge clk) begin
        if (deser_en)
            p_data <= {sampled_bit, p_data[7:1]};
    end

    always @(negedge clk) begin
        if (deser_en)
            cnt_deser <= cnt_deser + 1;
        if (par_err || stp_err || ovr_err)
            cnt_err <= cnt_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame; returns at the negedge of the cycle after the stop check point
    task automatic send_frame(input int p, input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop, input logic accept_at_cp, input logic [5:0] mid_presc);
        int waited;
        int stop_idx;
        int cp;
        tb_p     = p;
        prescale = 6'(p);
        par_en   = pen;
        RX_IN    = 1'b0;
        repeat (p) @(negedge clk);
        prescale = mid_presc;
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (p) @(negedge clk);
        end
        if (pen) begin
            RX_IN = pbit;
            repeat (p) @(negedge clk);
        end
        RX_IN    = stop;
        stop_idx = pen ? 10 : 9;
        cp       = p / 2 + 2;
        waited   = 0;
        while (!(int'(bit_cnt) == stop_idx && int'(edge_cnt) == cp) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("stop_cp_reached", 32'(waited < 200), 32'd1);
        if (accept_at_cp)
            rx_ready = 1'b1;
        @(negedge clk);
        if (accept_at_cp)
            rx_ready = 1'b0;
        RX_IN = 1'b1;
    endtask

    initial begin
        int d0;
        int e0;
        int stp_seen;
        int brk_seen;
        int en_after;

        rst      = 1'b0;
        RX_IN    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bit_cnt_reset", 32'(bit_cnt_reset), 32'd1);
        check("rst_enable", 32'(edge_bit_cnt_enable), 32'd0);
        check("rst_sample_en", 32'(data_sample_en), 32'd0);
        check("rst_deser_en", 32'(deser_en), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_errs", 32'({par_err, stp_err, ovr_err}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // P=8, no parity, 0xA5
        d0 = cnt_deser; e0 = cnt_err;
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
        check("t1_rx_valid", 32'(rx_valid), 32'd1);
        check("t1_rx_data", 32'(rx_data), 32'hA5);
        check("t1_deser_cnt", 32'(cnt_deser - d0), 32'd8);
        check("t1_no_err", 32'(cnt_err - e0), 32'd0);
        @(negedge clk);
        check("t1_valid_fall", 32'(rx_valid), 32'd0);

        // P=16, even parity, wrong parity bit on 0x3C
        par_typ = 1'b0;
        send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 6'd16);
        check("t2_par_err", 32'(par_err), 32'd1);
        check("t2_stp_err", 32'(stp_err), 32'd0);
        check("t2_rx_valid", 32'(rx_valid), 32'd0);
        @(negedge clk);
        check("t2_par_err_pulse", 32'(par_err), 32'd0);

        // P=32, bad stop on 0x55, prescale changed mid-frame
        d0 = cnt_deser;
        send_frame(32, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8);
        check("t3_stp_err", 32'(stp_err), 32'd1);
        check("t3_par_err", 32'(par_err), 32'd0);
        check("t3_bit_cnt_reset", 32'(bit_cnt_reset), 32'd1);
        check("t3_rx_valid", 32'(rx_valid), 32'd0);
        check("t3_deser_cnt", 32'(cnt_deser - d0), 32'd8);
        @(negedge clk);
        check("t3_stp_err_pulse", 32'(stp_err), 32'd0);

        // Start glitch: RX_IN low two clocks at P=16
        tb_p = 16; prescale = 6'd16;
        d0 = cnt_deser; e0 = cnt_err;
        RX_IN = 1'b0;
        @(negedge clk);
        check("t4_enable", 32'(edge_bit_cnt_enable), 32'd1);
        check("t4_bit_cnt_reset", 32'(bit_cnt_reset), 32'd0);
        check("t4_sample_en", 32'(data_sample_en), 32'd1);
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (16) @(negedge clk);
        check("t4_idle", 32'(bit_cnt_reset), 32'd1);
        check("t4_no_deser", 32'(cnt_deser - d0), 32'd0);
        check("t4_no_err", 32'(cnt_err - e0), 32'd0);

        // Overrun: consumer stalled across two good frames
        rx_ready = 1'b0;
        send_frame(8, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
        check("t5_first_valid", 32'(rx_valid), 32'd1);
        check("t5_first_data", 32'(rx_data), 32'h11);
        check("t5_first_ovr", 32'(ovr_err), 32'd0);
        send_frame(8, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
        check("t5_ovr_err", 32'(ovr_err), 32'd1);
        check("t5_data_held", 32'(rx_data), 32'h11);
        check("t5_valid_held", 32'(rx_valid), 32'd1);
        @(negedge clk);
        check("t5_ovr_pulse", 32'(ovr_err), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        check("t5_valid_fall", 32'(rx_valid), 32'd0);

        // Accept of old data in the same cycle as a new load
        rx_ready = 1'b0;
        send_frame(8, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
        send_frame(8, 8'h96, 1'b0, 1'b0, 1'b1, 1'b1, 6'd8);
        check("t6_valid", 32'(rx_valid), 32'd1);
        check("t6_data", 32'(rx_data), 32'h96);
        check("t6_no_ovr", 32'(ovr_err), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        check("t6_valid_fall", 32'(rx_valid), 32'd0);

        // Odd parity, correct parity bit on 0x07 (three ones -> parity 0)
        par_typ = 1'b1;
        send_frame(8, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 6'd8);
        check("t7_par_ok", 32'(par_err), 32'd0);
        check("t7_data", 32'(rx_data), 32'h07);
        par_typ = 1'b0;
        @(negedge clk);

        // Reset in the middle of a frame
        tb_p = 8; prescale = 6'd8; par_en = 1'b0;
        e0 = cnt_err;
        RX_IN = 1'b0;
        repeat (20) @(negedge clk);
        check("t8_running", 32'(edge_bit_cnt_enable), 32'd1);
        rst = 1'b0;
        #1;
        check("t8_async_reset", 32'(bit_cnt_reset), 32'd1);
        check("t8_async_enable", 32'(edge_bit_cnt_enable), 32'd0);
        @(negedge clk);
        RX_IN = 1'b1;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        check("t8_no_err", 32'(cnt_err - e0), 32'd0);
        check("t8_idle", 32'(bit_cnt_reset), 32'd1);

        // Line held low for 12 bit times at P=8
        stp_seen = 0; brk_seen = 0; en_after = 0;
        RX_IN = 1'b0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (stp_err)
                stp_seen++;
`ifdef UART_RX_BREAK_DET_EN
            if (brk_det)
                brk_seen++;
            if (brk_seen > 0 && edge_bit_cnt_enable)
                en_after++;
`else
            if (stp_seen > 0 && edge_bit_cnt_enable)
                en_after++;
`endif
        end
`ifdef UART_RX_BREAK_DET_EN
        check("t9_brk_det", 32'(brk_seen), 32'd1);
        check("t9_no_stp", 32'(stp_seen), 32'd0);
        check("t9_held_in_break", 32'(en_after), 32'd0);
        RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        check("t9_idle_after_rise", 32'(bit_cnt_reset), 32'd1);
        send_frame(8, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 6'd8);
        check("t9_after_break_data", 32'(rx_data), 32'h42);
        check("t9_after_break_valid", 32'(rx_valid), 32'd1);
`else
        check("t9_stp_err", 32'(stp_seen), 32'd1);
        check("t9_restarted", 32'(en_after > 0), 32'd1);
        check("t9_nothing_loaded", 32'(rx_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
